phase_acc: RTL and testbench

- Numerically controlled phase generator; sits directly upstream of the cos stage and drives its 16-bit signed phase input (sink).
- Produces one phase sample per enabled clock, at a fixed frequency or as a linear chirp.
- Configuration arrives over a valid/ready interface.
- Sweep completion is reported on a one-cycle done pulse.

---
 rtl/phase_acc_pkg.sv | 18 +
 rtl/phase_lfsr.sv | 19 +
 rtl/phase_acc.sv | 100 ++++++++++
 tb/tb_phase_acc.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/phase_acc_pkg.sv
// phase_acc_pkg: shared state encoding, default widths and dither LFSR constants
package phase_acc_pkg;

    localparam int ACC_WIDTH_DEF   = 32;
    localparam int PHASE_WIDTH_DEF = 16;
    localparam int COUNT_WIDTH_DEF = 16;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t RUN   = 2'd1;
    localparam state_t SWEEP = 2'd2;

    // x^16 + x^14 + x^13 + x^11 + 1 as a mask over bits [15:0]
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/phase_lfsr.sv
// phase_lfsr: 16-bit Fibonacci LFSR producing the phase dither word (used with PHASE_DITHER_EN)
module phase_lfsr
    import phase_acc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    output logic [15:0] value
);

    // shift in the tap parity only on cycles that emit a sample
    always_ff @(posedge clk) begin
        if (!reset)
            value <= LFSR_SEED;
        else if (advance)
            value <= {value[14:0], ^(value & LFSR_TAPS)};
    end

endmodule

// File: rtl/phase_acc.sv
// phase_acc: NCO phase generator with fixed-frequency and linear-chirp modes; PHASE_DITHER_EN adds LFSR dither
module phase_acc
    import phase_acc_pkg::*;
#(
    parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
    parameter int PHASE_WIDTH = PHASE_WIDTH_DEF,
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [ACC_WIDTH-1:0]   cfg_ftw,
    input  logic [ACC_WIDTH-1:0]   cfg_step,
    input  logic [COUNT_WIDTH-1:0] cfg_count,
    input  logic [PHASE_WIDTH-1:0] cfg_phase,
    input  logic                   enable,
    input  logic                   stop,
    output logic [PHASE_WIDTH-1:0] source,
    output logic                   source_valid,
    output logic                   busy,
    output logic                   done
);

    state_t                 state;
    logic [ACC_WIDTH-1:0]   acc;
    logic [ACC_WIDTH-1:0]   ftw;
    logic [ACC_WIDTH-1:0]   step;
    logic [COUNT_WIDTH-1:0] remaining;
    logic [PHASE_WIDTH-1:0] offset;
    logic [ACC_WIDTH-1:0]   tap;
    logic                   adv;
    logic                   accept;

    assign cfg_ready = (state != SWEEP) && !stop;
    assign busy      = state != IDLE;
    assign adv       = (state != IDLE) && enable && !stop;
    assign accept    = cfg_valid && cfg_ready;

`ifdef PHASE_DITHER_EN
    logic [15:0] dither;

    phase_lfsr u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (adv),
        .value   (dither)
    );

    assign tap = acc + (ACC_WIDTH'(dither) << (ACC_WIDTH - PHASE_WIDTH - 16));
`else
    assign tap = acc;
`endif

    // advance uses the pre-edge ftw/offset; a same-edge config load then overrides them
    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            acc          <= '0;
            ftw          <= '0;
            step         <= '0;
            remaining    <= '0;
            offset       <= '0;
            source       <= '0;
            source_valid <= 1'b0;
            done         <= 1'b0;
        end else begin
            done         <= 1'b0;
            source_valid <= adv;
            if (adv) begin
                source <= tap[ACC_WIDTH-1 -: PHASE_WIDTH] + offset;
                acc    <= acc + ftw;
                if (state == SWEEP) begin
                    ftw       <= ftw + step;
                    remaining <= remaining - COUNT_WIDTH'(1);
                    if (remaining == COUNT_WIDTH'(1)) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
            end
            if (accept) begin
                ftw    <= cfg_ftw;
                step   <= cfg_step;
                offset <= cfg_phase;
                if (state == IDLE) begin
                    acc       <= '0;
                    remaining <= cfg_count;
                    state     <= (cfg_count == '0) ? RUN : SWEEP;
                end else if (cfg_count != '0) begin
                    remaining <= cfg_count;
                    state     <= SWEEP;
                end
            end
            if (stop)
                state <= IDLE;
        end
    end

endmodule

// File: tb/tb_phase_acc.sv
// tb_phase_acc: directed test plan plus random traffic checked against an arithmetic phase model
module tb_phase_acc;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [31:0] cfg_ftw = '0;
    logic [31:0] cfg_step = '0;
    logic [15:0] cfg_count = '0;
    logic [15:0] cfg_phase = '0;
    logic        enable = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] source;
    logic        source_valid;
    logic        busy;
    logic        done;

    int vectors = 0;
    int miscompares = 0;

    // model: mode 0 idle, 1 free-running, 2 counted sweep
    int          m_mode;
    longint      m_acc, m_ftw, m_step;
    int          m_left;
    int          m_off, m_src;
    bit          m_vld, m_done;

    localparam longint ACC_MOD = 64'd1 << 32;

    phase_acc dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ftw      (cfg_ftw),
        .cfg_step     (cfg_step),
        .cfg_count    (cfg_count),
        .cfg_phase    (cfg_phase),
        .enable       (enable),
        .stop         (stop),
        .source       (source),
        .source_valid (source_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit ready, adv, take;
        if (!reset) begin
            m_mode = 0; m_acc = 0; m_ftw = 0; m_step = 0; m_left = 0;
            m_off = 0; m_src = 0; m_vld = 0; m_done = 0;
            return;
        end
        ready  = (m_mode != 2) && !stop;
        adv    = (m_mode != 0) && enable && !stop;
        take   = cfg_valid && ready;
        m_done = 0;
        m_vld  = adv;
        if (adv) begin
            m_src = int'(((m_acc / 65536) + m_off) % 65536);
            m_acc = (m_acc + m_ftw) % ACC_MOD;
            if (m_mode == 2) begin
                m_ftw  = (m_ftw + m_step) % ACC_MOD;
                m_left = m_left - 1;
                if (m_left == 0) begin
                    m_done = 1;
                    m_mode = 0;
                end
            end
        end
        if (take) begin
            m_ftw  = longint'(cfg_ftw);
            m_step = longint'(cfg_step);
            m_off  = int'(cfg_phase);
            if (m_mode == 0) begin
                m_acc  = 0;
                m_left = int'(cfg_count);
                m_mode = (cfg_count == 0) ? 1 : 2;
            end else if (cfg_count != 0) begin
                m_left = int'(cfg_count);
                m_mode = 2;
            end
        end
        if (stop)
            m_mode = 0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("source", 32'(source), 32'(m_src));
        chk("source_valid", 32'(source_valid), 32'(m_vld));
        chk("done", 32'(done), 32'(m_done));
        chk("busy", 32'(busy), 32'(m_mode != 0));
        chk("cfg_ready", 32'(cfg_ready), 32'((m_mode != 2) && !stop));
    endtask

    task automatic cfg(input logic [31:0] f, input logic [31:0] s, input logic [15:0] n, input logic [15:0] p);
        cfg_valid = 1'b1; cfg_ftw = f; cfg_step = s; cfg_count = n; cfg_phase = p;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic halt();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("reset_src", 32'(source), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        reset = 1'b1;

        enable = 1'b1;
        cfg(32'h0011_0000, 32'h0, 16'd0, 16'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_src", 32'(source), 32'(17 * i));
            chk("t1_busy", 32'(busy), 32'h1);
        end
        halt();

        cfg(32'h0001_0000, 32'h0001_0000, 16'd4, 16'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_src", 32'(source), 32'((i * (i + 1)) / 2));
            chk("t2_done", 32'(done), 32'(i == 3));
        end
        tick();
        chk("t2_hold", 32'(source), 32'd6);
        chk("t2_idle", 32'(busy), 32'h0);

        cfg(32'h8000_0000, 32'h0, 16'd0, 16'h4000);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_src", 32'(source), (i == 1) ? 32'hC000 : 32'h4000);
        end
        halt();

        cfg(32'h0011_0000, 32'h0, 16'd0, 16'h0);
        tick(); tick(); tick();
        chk("t4_pre", 32'(source), 32'd34);
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_hold", 32'(source), 32'd34);
            chk("t4_vld", 32'(source_valid), 32'h0);
        end
        cfg(32'h0001_0000, 32'h0, 16'd0, 16'h0);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_src", 32'(source), 32'(51 + i));
        end
        halt();

        cfg(32'h0001_0000, 32'h0, 16'd10, 16'h0);
        tick(); tick(); tick();
        cfg_valid = 1'b1; cfg_ftw = 32'h0123_0000; cfg_count = 16'd5;
        stop = 1'b1;
        tick();
        chk("t5_nodone", 32'(done), 32'h0);
        cfg_valid = 1'b0; stop = 1'b0;
        tick();
        chk("t5_idle", 32'(busy), 32'h0);

        cfg(32'h0002_0000, 32'h0, 16'd10, 16'h0);
        tick(); tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("t6_src", 32'(source), 32'h0);
        chk("t6_busy", 32'(busy), 32'h0);
        chk("t6_ready", 32'(cfg_ready), 32'h1);

        for (int i = 0; i < 400; i++) begin
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_ftw   = $urandom;
            cfg_step  = $urandom;
            cfg_count = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 8));
            cfg_phase = 16'($urandom);
            enable    = ($urandom_range(0, 3) != 0);
            stop      = ($urandom_range(0, 24) == 0);
            reset     = ($urandom_range(0, 99) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
